lcg_stream_gen: RTL
===================

Name: lcg_stream_gen

Overview:
- Parametrised linear congruential generator (state' = state*MULT + INC mod 2^WIDTH).
- Runtime reseed through a seed port; output is a valid/ready stream with one word per cycle of throughput.
- Selectable output tempering (high-slice or XOR-fold) and a delivered-word counter.
- Sits beside the existing fixed-width LCG sources and feeds the PRNG combiner/whitening stages, which may stall it.

Parameters:
- WIDTH, 128, state width in bits; >= 8, even.
- OUT_W, 64, output word width; 1 <= OUT_W <= WIDTH/2.
- MULT, 128'h2360ED051FC65DA44385DF649FCCF645, multiplier truncated to WIDTH bits; must satisfy MULT mod 4 == 1.
- INC, 128'h5851F42D4C957F2D14057B7EF767814F, increment truncated to WIDTH bits; must be odd.
- RESET_SEED, 128'h0, state loaded at reset, truncated to WIDTH bits.
- COUNT_W, 32, width of the delivered-word counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  generator enable; 0 freezes state, FSM, outputs and counter.
- seed_valid  in  1  reseed request.
- seed  in  WIDTH  new state value.
- seed_ready  out  1  reseed accept.
- fold_en  in  1  tempering select; sampled whenever a word is produced.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  OUT_W  random word.
- word_cnt  out  COUNT_W  words delivered since the last reset or reseed; wraps at 2^COUNT_W.

Behaviour:
- Reset (async, rst=0):
  - state=RESET_SEED, FSM=PRIME.
  - out_valid=0, out_data=0, word_cnt=0, seed_ready=0.
- seed_ready = 1 whenever rst=1 and en=1; otherwise 0. A seed is accepted on an edge where seed_valid && seed_ready.
- next(s) = low WIDTH bits of (s*MULT + INC). Full product is not required; only the low WIDTH bits matter.
- temper(s):
  - fold_en=0: s[WIDTH-1 -: OUT_W].
  - fold_en=1: s[WIDTH-1 -: OUT_W] ^ s[OUT_W-1:0].
- FSM PRIME:
  - out_valid=0.
  - On an edge with en=1 and no seed accept: state<=next(state), out_data<=temper(next(state)), out_valid<=1, FSM->RUN.
  - Latency from reset release or seed accept to first out_valid: 1 enabled edge.
- FSM RUN:
  - Handshake (out_valid && out_ready && en): state<=next(state), out_data<=temper(next(state)), out_valid stays 1, word_cnt+=1. Back-to-back handshakes deliver one new word per cycle.
  - out_ready=0: state, out_data and out_valid hold, so data is stable while valid.
  - A handshake with en=0 is not permitted; the consumer must ignore out_ready while en=0. The block ignores it: no state or count change.
- Seed accept (either FSM state):
  - state<=seed, FSM->PRIME, out_valid<=0, word_cnt<=0.
  - Has priority over a same-edge output handshake; the pending word is discarded and not counted.
- en=0: every register holds, including out_valid=1 and out_data, and seed_ready=0.
- fold_en changes affect only words produced after the change; the held out_data is not recomputed.
- word_cnt wraps from 2^COUNT_W-1 to 0 with no flag.
- Reset asserted mid-stream takes effect immediately (async), regardless of handshakes.
- With legal MULT/INC the state period is 2^WIDTH.
- All arithmetic is unsigned modulo 2^WIDTH.

Test Plan:
- Basic sequence: WIDTH=8, OUT_W=4, MULT=5, INC=3, RESET_SEED=1, fold_en=0, out_ready=1, en=1.
  - Release reset; out_valid must rise after 1 edge.
  - out_data must read 0x0, 0x2, 0xD, 0x4 (states 0x08, 0x2B, 0xDA, 0x45).
  - word_cnt must read 0,1,2,3 on the respective cycles.
- Fold: same configuration with fold_en=1 -> out_data must read 0x8, 0x9, 0x7, then 0x1 (0x45 -> 4^5).
- Backpressure:
  - Hold out_ready=0 for 5 cycles while out_valid=1 -> out_data and word_cnt must stay constant.
  - Then assert out_ready=1 -> sequence must resume with no word skipped or repeated.
- Reseed collision:
  - Assert seed_valid with seed=0x01 on the same edge as a handshake in RUN.
  - Required: out_valid=0 for 1 cycle, word_cnt=0, next words 0x0 and 0x2; the colliding word is not counted.
- Enable freeze: en=0 for 3 cycles with out_ready=1 -> no state, data or count change and seed_ready=0. Resume with en=1 -> sequence must continue identically.
- Counter wrap and async reset:
  - With COUNT_W=2, after 5 handshakes word_cnt must read 1.
  - Pulse rst low between clock edges -> outputs must clear immediately and the sequence must restart from RESET_SEED.

Source files
------------

// File: rtl/lcg_stream_gen.sv
// Linear congruential generator with runtime reseed, optional XOR-fold tempering
// and a valid/ready output stream that can be stalled by the downstream stages.
module lcg_stream_gen #(
    parameter int                 WIDTH      = 128,
    parameter int                 OUT_W      = 64,
    parameter logic [WIDTH-1:0]   MULT       = WIDTH'(128'h2360ED051FC65DA44385DF649FCCF645),
    parameter logic [WIDTH-1:0]   INC        = WIDTH'(128'h5851F42D4C957F2D14057B7EF767814F),
    parameter logic [WIDTH-1:0]   RESET_SEED = WIDTH'(128'h0),
    parameter int                 COUNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               seed_valid,
    input  logic [WIDTH-1:0]   seed,
    output logic               seed_ready,
    input  logic               fold_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [COUNT_W-1:0] word_cnt
);

    localparam logic [0:0] PRIME = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [WIDTH-1:0]   state_q, state_d;
    logic [0:0]         fsm_q, fsm_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [COUNT_W-1:0] word_cnt_q, word_cnt_d;

    logic [WIDTH-1:0]   state_nxt;
    logic [OUT_W-1:0]   hi_slice;
    logic [OUT_W-1:0]   lo_slice;
    logic [OUT_W-1:0]   tempered;
    logic               seed_acc;

    // Only the low WIDTH bits of the product are kept; the multiply is modulo 2^WIDTH.
    assign state_nxt = state_q * MULT + INC;
    assign hi_slice  = state_nxt[WIDTH-1 -: OUT_W];
    assign lo_slice  = state_nxt[OUT_W-1:0];
    assign tempered  = fold_en ? (hi_slice ^ lo_slice) : hi_slice;

    assign seed_ready = rst & en;
    assign seed_acc   = seed_valid & seed_ready;

    always_comb begin
        state_d     = state_q;
        fsm_d       = fsm_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        word_cnt_d  = word_cnt_q;
        if (seed_acc) begin
            // A reseed wins over a same-edge handshake; the pending word is dropped.
            state_d     = seed;
            fsm_d       = PRIME;
            out_valid_d = 1'b0;
            word_cnt_d  = '0;
        end else if (en) begin
            case (fsm_q)
                PRIME: begin
                    state_d     = state_nxt;
                    out_data_d  = tempered;
                    out_valid_d = 1'b1;
                    fsm_d       = RUN;
                end
                default: begin
                    if (out_valid_q && out_ready) begin
                        state_d    = state_nxt;
                        out_data_d = tempered;
                        word_cnt_d = word_cnt_q + COUNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RESET_SEED;
            fsm_q       <= PRIME;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            fsm_q       <= fsm_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign word_cnt  = word_cnt_q;

endmodule
